vga_pixel_timing: RTL and testbench



---
 rtl/vga_pixel_timing.sv | 179 +++++++++++++++++
 tb/tb_vga_pixel_timing.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_timing.sv
// ============================================================================
// Module   : vga_pixel_timing
// Purpose  : VGA raster timing generator fed by a valid/ready pixel stream,
//            with underflow counting and automatic frame re-lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module vga_pixel_timing #(
  parameter int C_resolution_x      = 1024,
  parameter int C_hsync_front_porch = 24,
  parameter int C_hsync_pulse       = 136,
  parameter int C_hsync_back_porch  = 160,
  parameter int C_resolution_y      = 768,
  parameter int C_vsync_front_porch = 3,
  parameter int C_vsync_pulse       = 6,
  parameter int C_vsync_back_porch  = 29,
  parameter int C_hsync_pol         = 0,
  parameter int C_vsync_pol         = 0,
  parameter int C_depth             = 2,
  parameter int C_bits_x            = 11,
  parameter int C_bits_y            = 11
) (
  input  logic                   clk_pixel,
  input  logic                   rst_n,
  input  logic [3*C_depth-1:0]   pix_data,
  input  logic                   pix_sof,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [C_depth-1:0]     vga_r,
  output logic [C_depth-1:0]     vga_g,
  output logic [C_depth-1:0]     vga_b,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic                   vga_blank,
  output logic                   frame_start,
  output logic                   locked,
  output logic [15:0]            underflow_cnt
);

  localparam int c_h_total = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch;
  localparam int c_v_total = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch;

  localparam logic [C_bits_x-1:0] c_h_last = C_bits_x'(c_h_total - 1);
  localparam logic [C_bits_x-1:0] c_h_vis  = C_bits_x'(C_resolution_x);
  localparam logic [C_bits_x-1:0] c_hs_beg = C_bits_x'(C_resolution_x + C_hsync_front_porch);
  localparam logic [C_bits_x-1:0] c_hs_end = C_bits_x'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
  localparam logic [C_bits_y-1:0] c_v_last = C_bits_y'(c_v_total - 1);
  localparam logic [C_bits_y-1:0] c_v_vis  = C_bits_y'(C_resolution_y);
  localparam logic [C_bits_y-1:0] c_vs_beg = C_bits_y'(C_resolution_y + C_vsync_front_porch);
  localparam logic [C_bits_y-1:0] c_vs_end = C_bits_y'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
  localparam logic c_hs_idle = (C_hsync_pol != 0) ? 1'b0 : 1'b1;
  localparam logic c_vs_idle = (C_vsync_pol != 0) ? 1'b0 : 1'b1;

  typedef enum logic [0:0] {
    ST_RESYNC = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t                 r_state;
  logic                   r_err;
  logic [C_bits_x-1:0]    r_h;
  logic [C_bits_y-1:0]    r_v;
  logic [3*C_depth-1:0]   r_rgb;
  logic                   r_hsync;
  logic                   r_vsync;
  logic                   r_blank;
  logic                   r_frame_start;
  logic [15:0]            r_underflow_cnt;

  logic w_h_last;
  logic w_v_last;
  logic w_eof;
  logic w_origin;
  logic w_vis;
  logic w_hs_act;
  logic w_vs_act;
  logic w_starve;
  logic w_misalign;
  logic w_relock;
  logic w_ready;

  assign w_h_last = (r_h == c_h_last);
  assign w_v_last = (r_v == c_v_last);
  assign w_eof    = w_h_last && w_v_last;
  assign w_origin = (r_h == '0) && (r_v == '0);
  assign w_vis    = (r_h < c_h_vis) && (r_v < c_v_vis);
  assign w_hs_act = (r_h >= c_hs_beg) && (r_h < c_hs_end);
  assign w_vs_act = (r_v >= c_vs_beg) && (r_v < c_vs_end);

  assign w_starve   = w_vis && !pix_valid;
  // Early SOF on a consumed pixel, or a non-SOF pixel sitting at the origin.
  assign w_misalign = (w_vis && pix_valid && pix_sof && !w_origin) ||
                      (w_origin && pix_valid && !pix_sof);
  assign w_relock   = pix_valid && pix_sof;

  // While resyncing, drain everything except the SOF pixel, which waits at the head.
  always_comb begin
    w_ready = 1'b0;
    if (r_state == ST_RUN) begin
      w_ready = w_vis;
    end else begin
      w_ready = pix_valid && !pix_sof;
    end
  end

  assign pix_ready = rst_n && w_ready;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_RESYNC;
      r_err           <= 1'b0;
      r_h             <= '0;
      r_v             <= '0;
      r_rgb           <= '0;
      r_hsync         <= c_hs_idle;
      r_vsync         <= c_vs_idle;
      r_blank         <= 1'b1;
      r_frame_start   <= 1'b0;
      r_underflow_cnt <= '0;
    end else begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end

      r_hsync       <= w_hs_act ^ c_hs_idle;
      r_vsync       <= w_vs_act ^ c_vs_idle;
      r_blank       <= !w_vis;
      r_frame_start <= w_origin;

      case (r_state)
        ST_RESYNC: begin
          r_rgb <= '0;
          if (w_eof && w_relock) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_rgb <= (w_vis && pix_valid) ? pix_data : '0;
          if (w_starve && (r_underflow_cnt != 16'hFFFF)) begin
            r_underflow_cnt <= r_underflow_cnt + 16'd1;
          end
          if (w_eof) begin
            // A failed frame drops lock unless SOF is already waiting.
            if (r_err) begin
              r_err <= 1'b0;
              if (!w_relock) begin
                r_state <= ST_RESYNC;
              end
            end
          end else if (w_starve || w_misalign) begin
            r_err <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RESYNC;
          r_rgb   <= '0;
        end
      endcase
    end
  end

  assign vga_r         = r_rgb[3*C_depth-1:2*C_depth];
  assign vga_g         = r_rgb[2*C_depth-1:C_depth];
  assign vga_b         = r_rgb[C_depth-1:0];
  assign vga_hsync     = r_hsync;
  assign vga_vsync     = r_vsync;
  assign vga_blank     = r_blank;
  assign frame_start   = r_frame_start;
  assign locked        = (r_state == ST_RUN);
  assign underflow_cnt = r_underflow_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_timing.sv
// ============================================================================
// Module   : tb_vga_pixel_timing
// Purpose  : Directed self-checking bench for vga_pixel_timing on a shrunk raster.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_pixel_timing;

  // Shrunk raster: 25 clocks per line, 11 lines per frame.
  localparam int X = 16, HFP = 2, HP = 4, HBP = 3, HT = X + HFP + HP + HBP;
  localparam int Y = 6,  VFP = 1, VP = 2, VBP = 2, VT = Y + VFP + VP + VBP;
  localparam int FRAME = HT * VT;
  localparam int D = 2;

  logic             clk_pixel = 1'b0;
  logic             rst_n = 1'b0;
  logic [3*D-1:0]   pix_data;
  logic             pix_sof;
  logic             pix_valid;
  logic             pix_ready;
  logic [D-1:0]     vga_r, vga_g, vga_b;
  logic             vga_hsync, vga_vsync, vga_blank;
  logic             frame_start, locked;
  logic [15:0]      underflow_cnt;

  vga_pixel_timing #(
    .C_resolution_x(X), .C_hsync_front_porch(HFP), .C_hsync_pulse(HP), .C_hsync_back_porch(HBP),
    .C_resolution_y(Y), .C_vsync_front_porch(VFP), .C_vsync_pulse(VP), .C_vsync_back_porch(VBP),
    .C_hsync_pol(0), .C_vsync_pol(0), .C_depth(D), .C_bits_x(11), .C_bits_y(11)
  ) dut (
    .clk_pixel(clk_pixel), .rst_n(rst_n),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
    .frame_start(frame_start), .locked(locked), .underflow_cnt(underflow_cnt)
  );

  always #5 clk_pixel = ~clk_pixel;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  int k = 0;
  bit en = 1'b0, starve = 1'b0, glitch = 1'b0;

  int fs1, fs2, hf1, hf2, hr1, vf1, vr1, blank_lo, rgb_nz, lock_hi;
  int op, oh, ov, exp_rgb, rgb_err, rdy, fsn, unl, zc;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] rgb();
    return {vga_r, vga_g, vga_b};
  endfunction

  task automatic drive();
    pix_valid = en && !starve;
    pix_sof   = (k == 0) || glitch;
    pix_data  = 6'(k % X);
  endtask

  // Advance one clock; the upstream model moves on only after a real handshake.
  task automatic step();
    logic hs;
    hs = pix_valid && pix_ready;
    @(posedge clk_pixel);
    if (rst_n) ecount++;
    if (hs) k = (k + 1) % (X * Y);
    @(negedge clk_pixel);
    drive();
    #1;
  endtask

  function automatic bit at_pos(input int h, input int v);
    return ((ecount % HT) == h) && (((ecount / HT) % VT) == v);
  endfunction

  task automatic wait_cur(input int h, input int v);
    for (int n = 0; n <= FRAME && !at_pos(h, v); n++) step();
  endtask

  task automatic wait_lock(input logic val, input int budget, input string tag);
    int n;
    n = 0;
    while (locked !== val && n < budget) begin
      step();
      n++;
    end
    chk_eq(tag, locked, val);
  endtask

  task automatic measure(input int n);
    logic ph, pv;
    fs1 = -1; fs2 = -1; hf1 = -1; hf2 = -1; hr1 = -1; vf1 = -1; vr1 = -1;
    blank_lo = 0; rgb_nz = 0; lock_hi = 0;
    ph = vga_hsync;
    pv = vga_vsync;
    for (int i = 0; i < n; i++) begin
      step();
      if (frame_start) begin
        if (fs1 < 0) fs1 = ecount;
        else if (fs2 < 0) fs2 = ecount;
      end
      if (ph && !vga_hsync) begin
        if (hf1 < 0) hf1 = ecount;
        else if (hf2 < 0) hf2 = ecount;
      end
      if (!ph && vga_hsync && hf1 >= 0 && hr1 < 0) hr1 = ecount;
      if (pv && !vga_vsync && vf1 < 0) vf1 = ecount;
      if (!pv && vga_vsync && vf1 >= 0 && vr1 < 0) vr1 = ecount;
      if (fs1 >= 0 && fs2 < 0 && !vga_blank) blank_lo++;
      if (rgb() != 6'd0) rgb_nz++;
      if (locked) lock_hi++;
      ph = vga_hsync;
      pv = vga_vsync;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset state, with a droppable pixel offered to prove ready stays low.
    en = 1'b1; k = 5;
    drive();
    repeat (3) @(negedge clk_pixel);
    #1;
    chk_eq("rst_ready", pix_ready, 0);
    chk_eq("rst_blank", vga_blank, 1);
    chk_eq("rst_hsync", vga_hsync, 1);
    chk_eq("rst_vsync", vga_vsync, 1);
    chk_eq("rst_rgb", rgb(), 0);
    chk_eq("rst_fs", frame_start, 0);
    chk_eq("rst_locked", locked, 0);
    chk_eq("rst_ufl", underflow_cnt, 0);

    // Free-running timing with no stream.
    en = 1'b0;
    drive();
    @(negedge clk_pixel);
    rst_n = 1'b1;
    ecount = 0;
    #1;
    measure(2 * FRAME + 5);
    chk_eq("fs_first", fs1, 1);
    chk_eq("fs_period", fs2 - fs1, FRAME);
    chk_eq("hs_start", hf1 - fs1, X + HFP);
    chk_eq("hs_width", hr1 - hf1, HP);
    chk_eq("hs_period", hf2 - hf1, HT);
    chk_eq("vs_start", vf1 - fs1, (Y + VFP) * HT);
    chk_eq("vs_width", vr1 - vf1, VP * HT);
    chk_eq("vis_count", blank_lo, X * Y);
    chk_eq("idle_rgb_nz", rgb_nz, 0);
    chk_eq("idle_locked", lock_hi, 0);

    // Stream joins mid-frame with a non-SOF pixel.
    k = 37; en = 1'b1;
    drive();
    #1;
    chk_eq("resync_drop_ready", pix_ready, 1);
    wait_lock(1'b1, 2 * FRAME + 10, "lock_midframe");
    chk_eq("sof_held", k, 0);
    chk_eq("lock_at_boundary", ecount % FRAME, 0);
    chk_eq("ufl_after_lock", underflow_cnt, 0);

    // One full locked frame with payload = x.
    rgb_err = 0; rdy = 0; fsn = 0; unl = 0;
    for (int i = 1; i <= FRAME; i++) begin
      step();
      op = ecount - 1;
      oh = op % HT;
      ov = (op / HT) % VT;
      exp_rgb = (oh < X && ov < Y) ? oh : 0;
      if (rgb() != 6'(exp_rgb)) rgb_err++;
      if (pix_ready) rdy++;
      if (frame_start) fsn++;
      if (!locked) unl++;
      if (i == 6) begin
        chk_eq("pix_5_0", rgb(), 5);
        chk_eq("blank_5_0", vga_blank, 0);
      end
    end
    chk_eq("run_rgb_errs", rgb_err, 0);
    chk_eq("run_ready_cnt", rdy, X * Y);
    chk_eq("run_fs_cnt", fsn, 1);
    chk_eq("run_unlocked", unl, 0);
    chk_eq("run_ufl", underflow_cnt, 0);

    // Starve 10 visible pixels.
    wait_cur(3, 2);
    starve = 1'b1;
    drive();
    #1;
    zc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rgb() == 6'd0) zc++;
    end
    starve = 1'b0;
    drive();
    #1;
    chk_eq("starve_zero_px", zc, 10);
    chk_eq("starve_ufl", underflow_cnt, 10);
    chk_eq("starve_still_locked", locked, 1);
    wait_cur(0, 0);
    chk_eq("unlock_after_starve", locked, 0);
    wait_lock(1'b1, 2 * FRAME + 10, "relock_after_starve");
    chk_eq("relock_boundary", ecount % FRAME, 0);
    chk_eq("ufl_kept", underflow_cnt, 10);

    // Early SOF mid-frame: upstream restarts at pixel 1 flagged as SOF.
    wait_cur(7, 3);
    k = 1; glitch = 1'b1;
    drive();
    #1;
    step();
    glitch = 1'b0;
    drive();
    #1;
    chk_eq("misaligned_shown", rgb(), 1);
    wait_cur(0, 0);
    chk_eq("unlock_after_sof", locked, 0);
    chk_eq("ufl_sof_err", underflow_cnt, 10);
    wait_lock(1'b1, 2 * FRAME + 10, "relock_after_sof");

    // Saturation, with upstream skipping the starved pixels to stay aligned.
    wait_cur(2, 1);
    force dut.r_underflow_cnt = 16'hFFFE;
    #1;
    release dut.r_underflow_cnt;
    chk_eq("ufl_preset", underflow_cnt, 16'hFFFE);
    starve = 1'b1;
    drive();
    #1;
    repeat (5) step();
    starve = 1'b0;
    k = k + 5;
    drive();
    #1;
    chk_eq("ufl_saturate", underflow_cnt, 16'hFFFF);
    wait_cur(0, 0);
    chk_eq("immediate_relock", locked, 1);
    chk_eq("ufl_sat_hold", underflow_cnt, 16'hFFFF);

    // Asynchronous reset in the middle of the visible area.
    wait_cur(10, 4);
    chk_eq("pre_rst_rgb", rgb(), 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_blank", vga_blank, 1);
    chk_eq("arst_hsync", vga_hsync, 1);
    chk_eq("arst_vsync", vga_vsync, 1);
    chk_eq("arst_rgb", rgb(), 0);
    chk_eq("arst_locked", locked, 0);
    chk_eq("arst_ufl", underflow_cnt, 0);
    chk_eq("arst_ready", pix_ready, 0);
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    rst_n = 1'b1;
    ecount = 0;
    drive();
    #1;
    measure(2 * HT + 5);
    chk_eq("post_rst_fs", fs1, 1);
    chk_eq("post_rst_hs_start", hf1 - fs1, X + HFP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
